imem_stream_loader: RTL and testbench
=====================================

Name: imem_stream_loader

Overview:
Parametrised instruction memory for the single-cycle CPU, replacing the hard-coded initialisation with a byte-stream program-load port (valid/ready handshake) and a registered fetch port.
- Memory is byte-addressed and big-endian: byte address A holds instruction bits 31:24.
- Sits between the boot/debug loader, which streams the program in, and the CPU fetch stage, which reads the PC address.
- Adds load sequencing, a ready indication and fetch error detection.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit instruction words; byte capacity is DEPTH_WORDS*4.
- ADDR_W, 32, width of the fetch address.
- CNT_W, 16, width of the loaded-byte counter; must satisfy 2^CNT_W > DEPTH_WORDS*4.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- load_start, in, 1: begin a new program load at byte address 0.
- load_valid, in, 1: load_data is valid.
- load_data, in, 8: program byte.
- load_last, in, 1: final byte of the program; qualified by load_valid.
- load_ready, out, 1: block accepts a byte this cycle.
- loaded_bytes, out, CNT_W: bytes accepted in the current or last load.
- mem_ready, out, 1: a complete program is resident and fetch is enabled.
- fetch_req, in, 1: fetch request.
- fetch_addr, in, ADDR_W: byte address (PC).
- fetch_valid, out, 1: fetch_instr and fetch_err are valid this cycle.
- fetch_instr, out, 32: instruction word.
- fetch_err, out, 1: misaligned or out-of-range fetch.

Behaviour:
- States: EMPTY, LOADING, RUN.
  - Reset state is EMPTY.
  - Memory array is not reset; contents are undefined until loaded.
- Reset values: load_ready=0, loaded_bytes=0, mem_ready=0, fetch_valid=0, fetch_instr=0, fetch_err=0.
- EMPTY:
  - load_start -> LOADING, byte pointer=0, loaded_bytes=0.
  - fetch_req is ignored.
- LOADING:
  - load_ready=1 combinationally while in this state.
  - Handshake: a byte is accepted on a rising edge where load_valid && load_ready. It is written to m[ptr]; then ptr++ and loaded_bytes++.
  - load_ready is independent of load_valid; the source may hold load_valid high across cycles.
  - Exit to RUN and set mem_ready=1 on the edge that accepts a byte with load_last=1, or that accepts the byte at address DEPTH_WORDS*4-1, whichever comes first.
  - Bytes offered after that edge are not accepted, since load_ready=0 in RUN.
  - load_last without load_valid has no effect.
  - load_start while LOADING restarts: ptr=0, loaded_bytes=0. If a byte is handshaken on the same edge, it is dropped.
  - A partially loaded program leaves untouched words with their prior contents.
  - fetch_req is ignored; fetch_valid=0.
- RUN:
  - Fetch latency is 1 cycle and throughput is 1 per cycle.
  - fetch_req sampled high at edge N gives fetch_valid=1 for exactly one cycle after edge N, with:
    - fetch_instr = {m[a], m[a+1], m[a+2], m[a+3]}, where a = fetch_addr;
    - fetch_err = 0.
  - Error case: if fetch_addr[1:0] != 0, or fetch_addr > DEPTH_WORDS*4-4 (compared at full ADDR_W width, so no wrap), then fetch_valid=1, fetch_err=1, fetch_instr=0 (NOP).
  - Back-to-back requests give fetch_valid high on consecutive cycles.
  - With fetch_req low, fetch_valid=0 next cycle; fetch_instr and fetch_err hold their last values.
  - load_start -> LOADING, mem_ready=0, ptr=0. load_start has priority over a same-cycle fetch_req, which is dropped (fetch_valid=0 next cycle).
- Reset mid-load or mid-fetch:
  - Immediate return to EMPTY with all outputs at reset values.
  - Any partial load is discarded from the status outputs; the array contents are don't-care.

Test Plan:
- Reset, then load_start, then stream 12 bytes 20 10 00 00 / 20 11 00 00 / 20 08 00 28 with load_last on the 12th byte. Require load_ready=1 for all 12 accepts, then mem_ready=1 and loaded_bytes=12. Then fetch_addr=0,4,8 back-to-back -> fetch_valid high 3 consecutive cycles with 0x20100000, 0x20110000, 0x20080028, fetch_err=0.
- load_valid toggled 1/0 pseudo-randomly during a 16-byte load -> only handshaken bytes written; loaded_bytes=16; fetch of word 3 returns the bytes in stream order.
- In RUN, fetch_addr=2 -> fetch_valid=1, fetch_err=1, fetch_instr=0. fetch_addr=DEPTH_WORDS*4 (256) -> fetch_err=1. fetch_addr=252 -> fetch_err=0.
- Load without load_last for DEPTH_WORDS*4 bytes -> RUN entered on byte 256; load_ready=0 the next cycle; byte 257 is not accepted.
- In RUN, assert load_start and fetch_req on the same edge -> no fetch_valid, mem_ready=0, load_ready=1. Reload word 0 with 0x08000003 -> fetch 0 returns 0x08000003, and word 1 keeps its old value.
- Assert rst_n=0 mid-load after 5 bytes -> outputs zero asynchronously; loaded_bytes=0; fetch_req ignored until a new load completes.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Byte-stream loadable, big-endian instruction memory with a registered fetch port.
// A loader streams the program in over a valid/ready handshake, then the CPU fetches word-aligned PCs.
module imem_stream_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [CNT_W-1:0]  loaded_bytes,
  output logic              mem_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err
);

  localparam int BYTE_CAP = DEPTH_WORDS * 4;
  localparam int BYTE_AW  = $clog2(BYTE_CAP);
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(BYTE_CAP - 4);
  localparam logic [CNT_W-1:0]  LAST_BYTE_CNT  = CNT_W'(BYTE_CAP - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Full-width compare so a PC near 2^ADDR_W cannot wrap back into range.
  function automatic logic fetch_bad(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'd0) || (addr > LAST_WORD_ADDR);
  endfunction

  logic [7:0]         mem_r [BYTE_CAP];
  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   count_r;
  logic               accept_s;
  logic               load_done_s;
  logic               fetch_go_s;
  logic [BYTE_AW-3:0] word_idx_s;
  logic [31:0]        word_s;

  // A byte arriving together with load_start is dropped; the restart wins.
  assign accept_s    = (state_r == ST_LOADING) && load_valid && !load_start;
  assign load_done_s = accept_s && (load_last || (count_r == LAST_BYTE_CNT));
  assign fetch_go_s  = (state_r == ST_RUN) && fetch_req && !load_start;

  assign word_idx_s = fetch_addr[BYTE_AW-1:2];
  assign word_s     = {mem_r[{word_idx_s, 2'd0}], mem_r[{word_idx_s, 2'd1}],
                       mem_r[{word_idx_s, 2'd2}], mem_r[{word_idx_s, 2'd3}]};

  assign load_ready   = (state_r == ST_LOADING);
  assign loaded_bytes = count_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_start) begin
          next_state_s = ST_LOADING;
        end else begin
          next_state_s = ST_EMPTY;
        end
      end
      ST_LOADING: begin
        if (load_start) begin
          next_state_s = ST_LOADING;
        end else if (load_done_s) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_LOADING;
        end
      end
      ST_RUN: begin
        if (load_start) begin
          next_state_s = ST_LOADING;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: next_state_s = ST_EMPTY;
    endcase
  end

  // Byte pointer doubles as the loaded-byte count; mem_ready tracks RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r   <= {CNT_W{1'b0}};
      mem_ready <= 1'b0;
    end else begin
      if (load_start) begin
        count_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
      mem_ready <= (next_state_s == ST_RUN);
    end
  end

  // Program storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[count_r[BYTE_AW-1:0]] <= load_data;
    end
  end

  // Registered fetch port; data and error hold when no fetch is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fetch_instr <= 32'd0;
      fetch_err   <= 1'b0;
    end else if (fetch_go_s) begin
      fetch_valid <= 1'b1;
      if (fetch_bad(fetch_addr)) begin
        fetch_instr <= 32'd0;
        fetch_err   <= 1'b1;
      end else begin
        fetch_instr <= word_s;
        fetch_err   <= 1'b0;
      end
    end else begin
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed self-checking bench for imem_stream_loader with hand-computed expectations.
module tb_imem_stream_loader;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic [15:0] loaded_bytes;
  logic        mem_ready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  imem_stream_loader #(.DEPTH_WORDS(64), .ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .loaded_bytes (loaded_bytes),
    .mem_ready    (mem_ready),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .fetch_instr  (fetch_instr),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] data, input logic last, input bit check_ready);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    if (check_ready) chk("load_ready_on_accept", {31'd0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  logic [7:0] prog1 [12];

  initial begin
    prog1 = '{8'h20, 8'h10, 8'h00, 8'h00, 8'h20, 8'h11, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h28};
    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    load_last = 1'b0; fetch_req = 1'b0; fetch_addr = 32'd0;
    step(); step();
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_loaded_bytes", {16'd0, loaded_bytes}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_fetch_instr", fetch_instr, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    fetch_req = 1'b1;
    step();
    chk("empty_ignores_fetch", {31'd0, fetch_valid}, 32'd0);
    fetch_req = 1'b0;

    // 12-byte program with load_last
    pulse_start();
    chk("loading_ready", {31'd0, load_ready}, 32'd1);
    chk("loading_count0", {16'd0, loaded_bytes}, 32'd0);
    for (int i = 0; i < 12; i++) send_byte(prog1[i], (i == 11), 1'b1);
    chk("p1_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("p1_loaded_bytes", {16'd0, loaded_bytes}, 32'd12);
    chk("p1_ready_low", {31'd0, load_ready}, 32'd0);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk("p1_v0", {31'd0, fetch_valid}, 32'd1);
    chk("p1_w0", fetch_instr, 32'h2010_0000);
    chk("p1_e0", {31'd0, fetch_err}, 32'd0);
    fetch_addr = 32'd4;
    step();
    chk("p1_v1", {31'd0, fetch_valid}, 32'd1);
    chk("p1_w1", fetch_instr, 32'h2011_0000);
    fetch_addr = 32'd8;
    step();
    chk("p1_v2", {31'd0, fetch_valid}, 32'd1);
    chk("p1_w2", fetch_instr, 32'h2008_0028);
    chk("p1_e2", {31'd0, fetch_err}, 32'd0);
    fetch_req = 1'b0;
    step();
    chk("idle_valid_low", {31'd0, fetch_valid}, 32'd0);
    chk("idle_instr_hold", fetch_instr, 32'h2008_0028);

    // 16-byte load with gaps in load_valid; gap bytes carry junk that must not land
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if ((i % 3) == 1) begin
        load_valid = 1'b0; load_data = 8'hEE; load_last = 1'b1;
        step();
        load_last = 1'b0;
      end
      send_byte(8'h30 + 8'(i), (i == 15), 1'b0);
    end
    chk("p2_loaded_bytes", {16'd0, loaded_bytes}, 32'd16);
    chk("p2_mem_ready", {31'd0, mem_ready}, 32'd1);
    fetch_req = 1'b1; fetch_addr = 32'd12;
    step();
    chk("p2_w3", fetch_instr, 32'h3C3D_3E3F);
    fetch_addr = 32'd0;
    step();
    chk("p2_w0", fetch_instr, 32'h3031_3233);

    // fetch error cases
    fetch_addr = 32'd2;
    step();
    chk("mis_valid", {31'd0, fetch_valid}, 32'd1);
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_instr", fetch_instr, 32'd0);
    fetch_addr = 32'd256;
    step();
    chk("oor_err", {31'd0, fetch_err}, 32'd1);
    chk("oor_instr", fetch_instr, 32'd0);
    fetch_addr = 32'hFFFF_FFFC;
    step();
    chk("wrap_err", {31'd0, fetch_err}, 32'd1);
    fetch_addr = 32'd252;
    step();
    chk("top_valid", {31'd0, fetch_valid}, 32'd1);
    chk("top_err", {31'd0, fetch_err}, 32'd0);
    fetch_req = 1'b0;

    // full-capacity load without load_last
    pulse_start();
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'hA5, 1'b0, 1'b0);
    chk("full_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("full_ready_low", {31'd0, load_ready}, 32'd0);
    chk("full_count", {16'd0, loaded_bytes}, 32'd256);
    send_byte(8'h77, 1'b1, 1'b0);
    chk("byte257_rejected", {16'd0, loaded_bytes}, 32'd256);
    fetch_req = 1'b1; fetch_addr = 32'd252;
    step();
    chk("full_w63", fetch_instr, 32'h5958_5B5A);
    fetch_addr = 32'd0;
    step();
    chk("full_w0", fetch_instr, 32'hA5A4_A7A6);

    // load_start beats same-cycle fetch; partial reload keeps word 1
    load_start = 1'b1; fetch_addr = 32'd4;
    step();
    load_start = 1'b0; fetch_req = 1'b0;
    chk("restart_no_fetch", {31'd0, fetch_valid}, 32'd0);
    chk("restart_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("restart_load_ready", {31'd0, load_ready}, 32'd1);
    chk("restart_count", {16'd0, loaded_bytes}, 32'd0);
    send_byte(8'h08, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h03, 1'b1, 1'b0);
    chk("reload_ready", {31'd0, mem_ready}, 32'd1);
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step();
    chk("reload_w0", fetch_instr, 32'h0800_0003);
    fetch_addr = 32'd4;
    step();
    chk("reload_w1_kept", fetch_instr, 32'hA1A0_A3A2);
    fetch_req = 1'b0;
    step();

    // asynchronous reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(8'h55, 1'b0, 1'b0);
    chk("mid_count5", {16'd0, loaded_bytes}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("arst_count", {16'd0, loaded_bytes}, 32'd0);
    chk("arst_mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("arst_instr", fetch_instr, 32'd0);
    step();
    rst_n = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'd0;
    step(); step();
    chk("post_rst_fetch_ignored", {31'd0, fetch_valid}, 32'd0);
    chk("post_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    fetch_req = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
